hms_timer_ctrl: RTL and testbench
=================================

# hms_timer_ctrl

Parametrised hours/minutes/seconds BCD timer with six 7-segment outputs, the next generation of the seconds/minutes/hours display timer. Adds run/pause, up/down counting, validated preset load, configurable hour modulus, a countdown-expiry flag and a per-second tick output. Sits between the board clock and the HEX0..HEX5 display pins. Status outputs drive LEDs or a host controller.

## Interface
- CLOCK_FREQ, 50_000_000: clk cycles per second; minimum 2.
- HOURS_MOD, 24: hour wrap modulus, legal range 2..99; hours count 0..HOURS_MOD-1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_run  in  1  level; 1 = counting enabled, 0 = paused.
- i_down  in  1  level; 0 = count up, 1 = count down.
- i_load  in  1  one-cycle pulse; loads the preset time.
- i_set_hh, i_set_mm, i_set_ss  in  8 each  preset time, packed BCD, tens digit in [7:4].
- o_tick  out  1  one-cycle pulse on every one-second step.
- o_wrap  out  1  one-cycle pulse when the up-count wraps to 00:00:00.
- o_expired  out  1  sticky; the countdown has reached 00:00:00.
- o_load_err  out  1  one-cycle pulse; preset rejected.
- o_HEX0/o_HEX1  out  7 each  seconds units/tens.
- o_HEX2/o_HEX3  out  7 each  minutes units/tens.
- o_HEX4/o_HEX5  out  7 each  hours units/tens.

## Operation
- Segment encoding: bit order gfedcba, active-low. 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000. Any other nibble = 7'b1111111.
- Prescaler counts 0..CLOCK_FREQ-1 only in RUN. When it reaches CLOCK_FREQ-1 it returns to 0 and a step occurs. It holds its value while paused.
- Up step: ss+1. At 59, ss→00 and mm is carried; at 59, mm→00 and hh is carried; at HOURS_MOD-1, hh→00 and o_wrap fires. All digits are BCD-correct.
- Down step: mirror borrow chain. 00 ss→59 with mm-1; 00 mm→59 with hh-1. A step that produces 00:00:00 sets o_expired.
- FSM states:
  - IDLE: i_run=1 → RUN.
  - RUN: i_run=0 → IDLE. Step to zero in down mode → EXPIRED. i_down=1 with time already 00:00:00 → EXPIRED on the next edge, no step.
  - EXPIRED: counting stops and the prescaler is cleared. Exits only via a valid load (→ IDLE) or reset.
- Load validation: every digit ≤ 9, ss ≤ 0x59, mm ≤ 0x59, hh < HOURS_MOD (BCD compare).
  - Valid load: time set, prescaler cleared, o_expired cleared.
  - Invalid load: o_load_err fires; time, prescaler and state are unchanged.
- Priority within one cycle: reset > i_load > step. A load coinciding with a step wins, and that step is discarded.
- A change of i_down takes effect at the next step; the prescaler is not disturbed.
- Reset values: time 00:00:00, prescaler 0, state IDLE, all o_HEX = 7'b1000000, o_tick/o_wrap/o_load_err/o_expired = 0.

## Timing
- Time registers update on the edge where a step occurs or i_load is sampled.
- o_tick, o_wrap and o_expired assert in the same cycle the new time is registered.
- o_HEX outputs are registered one cycle after the time registers; display latency is 1 cycle.
- In RUN with prescaler=0, the first step occurs CLOCK_FREQ cycles later. Subsequent steps come every CLOCK_FREQ cycles while i_run stays high.
- o_load_err asserts the cycle after the rejected i_load.
- Asynchronous reset clears all state immediately, mid-count included. The first step after release needs a full CLOCK_FREQ cycles in RUN.
- Pulse outputs are never longer than 1 cycle.

## Test plan
- CLOCK_FREQ=4, reset then i_run=1, up: first o_tick 4 cycles after run; after 60 ticks time is 00:01:00, o_HEX0=7'b1000000, o_HEX2=7'b1111001.
- Load 23:59:58, up, run: after 2 ticks time is 00:00:00, o_wrap pulses with the second tick, o_HEX5..0 all 7'b1000000.
- Load 00:01:01, down, run: ticks give 00:01:00, then 00:00:59, …; at 00:00:00 o_expired=1 and the state is EXPIRED. With 40 further cycles there is no o_tick and no time change, and a valid load of 00:00:05 clears o_expired.
- Load ss=8'h60 → o_load_err pulse, time unchanged. Load ss=8'h0A → rejected. Load hh=8'h24 with HOURS_MOD=24 → rejected. Load hh=8'h23 → accepted. With HOURS_MOD=12, up from 11:59:59 → 00:00:00.
- Pause/resume: drop i_run 2 cycles after a tick, hold 10 cycles (no tick), raise i_run → next tick 2 cycles later. i_load coincident with a tick cycle → loaded value shown, no extra step.
- Assert rst_n=0 between clock edges during RUN at 00:00:37 → all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hms_timer_ctrl.sv
// hms_timer_ctrl: hours/minutes/seconds BCD timer with run/pause, up/down
// counting, validated preset load, configurable hour modulus, countdown
// expiry flag, per-second tick pulse and six active-low 7-segment outputs.
module hms_timer_ctrl #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int HOURS_MOD  = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic       i_down,
    input  logic       i_load,
    input  logic [7:0] i_set_hh,
    input  logic [7:0] i_set_mm,
    input  logic [7:0] i_set_ss,
    output logic       o_tick,
    output logic       o_wrap,
    output logic       o_expired,
    output logic       o_load_err,
    output logic [6:0] o_HEX0,
    output logic [6:0] o_HEX1,
    output logic [6:0] o_HEX2,
    output logic [6:0] o_HEX3,
    output logic [6:0] o_HEX4,
    output logic [6:0] o_HEX5
);

    localparam int             PW     = (CLOCK_FREQ > 2) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0]  PS_MAX = PW'(CLOCK_FREQ - 1);
    // Largest legal hour value, held in packed BCD so it compares directly
    // against the hour register.
    localparam logic [7:0]     HH_MAX = {4'((HOURS_MOD - 1) / 10), 4'((HOURS_MOD - 1) % 10)};
    localparam logic [6:0]     SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] ps;
    logic [7:0]    ss, mm, hh;

    logic [7:0] ss_step, mm_step, hh_step;
    logic       wrap_step;
    logic       zero_step;
    logic       time_zero;
    logic       count_en;
    logic       load_ok;

    // BCD increment of a two-digit field, rolling over to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD decrement of a two-digit field, rolling under from 00 to max.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'h9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Both digits of a packed BCD byte are decimal.
    function automatic logic digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Active-low gfedcba segment pattern for one BCD digit; blank otherwise.
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Next time value for one step in the current direction, plus wrap/zero flags.
    always_comb begin
        ss_step   = ss;
        mm_step   = mm;
        hh_step   = hh;
        wrap_step = 1'b0;
        if (!i_down) begin
            ss_step = bcd_inc(ss, 8'h59);
            if (ss == 8'h59) begin
                mm_step = bcd_inc(mm, 8'h59);
                if (mm == 8'h59) begin
                    hh_step   = bcd_inc(hh, HH_MAX);
                    wrap_step = (hh == HH_MAX);
                end
            end
        end else begin
            ss_step = bcd_dec(ss, 8'h59);
            if (ss == 8'h00) begin
                mm_step = bcd_dec(mm, 8'h59);
                if (mm == 8'h00)
                    hh_step = bcd_dec(hh, HH_MAX);
            end
        end
        zero_step = (ss_step == 8'h00) && (mm_step == 8'h00) && (hh_step == 8'h00);
    end

    // Preset validation and count enable. Counting is suppressed when a
    // countdown would start from 00:00:00, so that case expires without a step.
    always_comb begin
        time_zero = (ss == 8'h00) && (mm == 8'h00) && (hh == 8'h00);
        load_ok   = digits_ok(i_set_ss) && digits_ok(i_set_mm) && digits_ok(i_set_hh) &&
                    (i_set_ss <= 8'h59) && (i_set_mm <= 8'h59) && (i_set_hh <= HH_MAX);
        count_en  = i_run && (state != EXPIRED) && !(i_down && time_zero);
    end

    // Control FSM, prescaler, time registers and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ps         <= '0;
            ss         <= 8'h00;
            mm         <= 8'h00;
            hh         <= 8'h00;
            o_tick     <= 1'b0;
            o_wrap     <= 1'b0;
            o_expired  <= 1'b0;
            o_load_err <= 1'b0;
        end else begin
            o_tick     <= 1'b0;
            o_wrap     <= 1'b0;
            o_load_err <= 1'b0;
            if (i_load) begin
                // A load pre-empts any step due this cycle; a rejected load
                // freezes everything except the error pulse.
                if (load_ok) begin
                    ss        <= i_set_ss;
                    mm        <= i_set_mm;
                    hh        <= i_set_hh;
                    ps        <= '0;
                    o_expired <= 1'b0;
                    if (state == EXPIRED)
                        state <= IDLE;
                end else begin
                    o_load_err <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (i_run)
                            state <= RUN;
                    end
                    RUN: begin
                        if (!i_run) begin
                            state <= IDLE;
                        end else if (i_down && time_zero) begin
                            state     <= EXPIRED;
                            o_expired <= 1'b1;
                            ps        <= '0;
                        end
                    end
                    EXPIRED: begin
                        ps <= '0;
                    end
                    default: state <= IDLE;
                endcase
                if (count_en) begin
                    if (ps == PS_MAX) begin
                        ps     <= '0;
                        ss     <= ss_step;
                        mm     <= mm_step;
                        hh     <= hh_step;
                        o_tick <= 1'b1;
                        o_wrap <= !i_down && wrap_step;
                        if (i_down && zero_step) begin
                            state     <= EXPIRED;
                            o_expired <= 1'b1;
                        end
                    end else begin
                        ps <= ps + 1'b1;
                    end
                end
            end
        end
    end

    // Segment drivers, registered one cycle behind the time registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_HEX0 <= SEG_ZERO;
            o_HEX1 <= SEG_ZERO;
            o_HEX2 <= SEG_ZERO;
            o_HEX3 <= SEG_ZERO;
            o_HEX4 <= SEG_ZERO;
            o_HEX5 <= SEG_ZERO;
        end else begin
            o_HEX0 <= seg(ss[3:0]);
            o_HEX1 <= seg(ss[7:4]);
            o_HEX2 <= seg(mm[3:0]);
            o_HEX3 <= seg(mm[7:4]);
            o_HEX4 <= seg(hh[3:0]);
            o_HEX5 <= seg(hh[7:4]);
        end
    end

endmodule

// File: tb/tb_hms_timer_ctrl.sv
// Directed bench for hms_timer_ctrl: a 24-hour instance and a 12-hour
// instance share all inputs; CLOCK_FREQ=4 keeps one second to four cycles.
module tb_hms_timer_ctrl;

    localparam int CF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_run = 1'b0;
    logic       i_down = 1'b0;
    logic       i_load = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;

    logic       tick, wrap, expired, load_err;
    logic [6:0] h0, h1, h2, h3, h4, h5;
    logic       tick12, wrap12, expired12, load_err12;
    logic [6:0] g0, g1, g2, g3, g4, g5;
    logic [41:0] d24, d12;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] hh, mm, ss;
        logic       err;
        logic [7:0] ehh, emm, ess;
    } load_vec_t;

    load_vec_t vecs[8];

    assign d24 = {h5, h4, h3, h2, h1, h0};
    assign d12 = {g5, g4, g3, g2, g1, g0};

    hms_timer_ctrl #(.CLOCK_FREQ(CF), .HOURS_MOD(24)) u24 (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_down(i_down), .i_load(i_load),
        .i_set_hh(set_hh), .i_set_mm(set_mm), .i_set_ss(set_ss),
        .o_tick(tick), .o_wrap(wrap), .o_expired(expired), .o_load_err(load_err),
        .o_HEX0(h0), .o_HEX1(h1), .o_HEX2(h2), .o_HEX3(h3), .o_HEX4(h4), .o_HEX5(h5)
    );

    hms_timer_ctrl #(.CLOCK_FREQ(CF), .HOURS_MOD(12)) u12 (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_down(i_down), .i_load(i_load),
        .i_set_hh(set_hh), .i_set_mm(set_mm), .i_set_ss(set_ss),
        .o_tick(tick12), .o_wrap(wrap12), .o_expired(expired12), .o_load_err(load_err12),
        .o_HEX0(g0), .o_HEX1(g1), .o_HEX2(g2), .o_HEX3(g3), .o_HEX4(g4), .o_HEX5(g5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_exp(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] disp_exp(input logic [7:0] hh, mm, ss);
        return {seg_exp(hh[7:4]), seg_exp(hh[3:0]), seg_exp(mm[7:4]),
                seg_exp(mm[3:0]), seg_exp(ss[7:4]), seg_exp(ss[3:0])};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns the number of edges until o_tick is seen, or -1 if none within budget.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (tick) return;
        end
        n = -1;
    endtask

    // Called 1 time unit after a rising edge: one-cycle load pulse, then
    // checks the error pulse, its length and the resulting display.
    task automatic do_load(input logic [7:0] hh, mm, ss, input logic exp_err,
                           input logic [7:0] ehh, emm, ess, input string name);
        set_hh = hh; set_mm = mm; set_ss = ss; i_load = 1'b1;
        @(posedge clk); #1;
        i_load = 1'b0;
        check({name, "_err"}, load_err, exp_err);
        @(posedge clk); #1;
        check({name, "_errlen"}, load_err, 1'b0);
        check({name, "_disp"}, d24, disp_exp(ehh, emm, ess));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int cnt;

        vecs[0] = '{8'h12, 8'h34, 8'h56, 1'b0, 8'h12, 8'h34, 8'h56};
        vecs[1] = '{8'h12, 8'h34, 8'h60, 1'b1, 8'h12, 8'h34, 8'h56};
        vecs[2] = '{8'h12, 8'h34, 8'h0A, 1'b1, 8'h12, 8'h34, 8'h56};
        vecs[3] = '{8'h24, 8'h00, 8'h00, 1'b1, 8'h12, 8'h34, 8'h56};
        vecs[4] = '{8'h23, 8'h59, 8'h58, 1'b0, 8'h23, 8'h59, 8'h58};
        vecs[5] = '{8'h10, 8'h5A, 8'h00, 1'b1, 8'h23, 8'h59, 8'h58};
        vecs[6] = '{8'h09, 8'h00, 8'h00, 1'b0, 8'h09, 8'h00, 8'h00};
        vecs[7] = '{8'h0F, 8'h00, 8'h00, 1'b1, 8'h09, 8'h00, 8'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_disp", d24, disp_exp(8'h00, 8'h00, 8'h00));
        check("rst_flags", {tick, wrap, expired, load_err}, 4'b0000);

        // Up count from reset: first tick after 4 cycles, then 00:01:00 after 60
        i_run = 1'b1;
        wait_tick(10, n);
        check("first_tick", n, 4);
        bad = 0;
        for (int i = 0; i < 59; i++) begin
            wait_tick(10, n);
            if (n != 4) bad++;
        end
        check("tick_period", bad, 0);
        i_run = 1'b0;
        @(posedge clk); #1;
        check("one_min_disp", d24, disp_exp(8'h00, 8'h01, 8'h00));
        check("one_min_hex0", h0, 7'b1000000);
        check("one_min_hex2", h2, 7'b1111001);

        // Load validation table
        for (int i = 0; i < 8; i++)
            do_load(vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].err,
                    vecs[i].ehh, vecs[i].emm, vecs[i].ess, $sformatf("load%0d", i));

        // Wrap from 23:59:58
        do_load(8'h23, 8'h59, 8'h58, 1'b0, 8'h23, 8'h59, 8'h58, "wrap_load");
        i_run = 1'b1;
        wait_tick(10, n);
        check("wrap_tick1", n, 4);
        check("wrap_first", wrap, 1'b0);
        wait_tick(10, n);
        check("wrap_tick2", n, 4);
        check("wrap_second", wrap, 1'b1);
        i_run = 1'b0;
        @(posedge clk); #1;
        check("wrap_len", wrap, 1'b0);
        check("wrap_disp", d24, disp_exp(8'h00, 8'h00, 8'h00));

        // Down mode at 00:00:00 expires without a step
        i_down = 1'b1;
        i_run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (tick) cnt++;
        end
        check("zero_down_noticks", cnt, 0);
        check("zero_down_expired", expired, 1'b1);
        check("zero_down_disp", d24, disp_exp(8'h00, 8'h00, 8'h00));
        i_run = 1'b0;

        // Countdown from 00:01:01 to expiry
        do_load(8'h00, 8'h01, 8'h01, 1'b0, 8'h00, 8'h01, 8'h01, "down_load");
        check("down_load_clr", expired, 1'b0);
        i_run = 1'b1;
        wait_tick(10, n);
        check("down_tick1", n, 4);
        @(posedge clk); #1;
        check("down_disp1", d24, disp_exp(8'h00, 8'h01, 8'h00));
        wait_tick(10, n);
        @(posedge clk); #1;
        check("down_disp2", d24, disp_exp(8'h00, 8'h00, 8'h59));
        bad = 0;
        for (int i = 0; i < 58; i++) begin
            wait_tick(10, n);
            if (n < 0) bad++;
        end
        check("down_ticks", bad, 0);
        check("down_not_yet", expired, 1'b0);
        wait_tick(10, n);
        check("down_last_tick", n, 4);
        check("down_expired", expired, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (tick) cnt++;
        end
        check("expired_noticks", cnt, 0);
        check("expired_disp", d24, disp_exp(8'h00, 8'h00, 8'h00));
        check("expired_sticky", expired, 1'b1);
        do_load(8'h00, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00, 8'h05, "exp_load");
        check("expired_cleared", expired, 1'b0);
        i_run = 1'b0;
        i_down = 1'b0;
        @(posedge clk); #1;

        // Hour modulus 12 versus 24 from 11:59:59
        do_load(8'h11, 8'h59, 8'h59, 1'b0, 8'h11, 8'h59, 8'h59, "mod_load");
        i_run = 1'b1;
        wait_tick(10, n);
        check("mod_tick", n, 4);
        check("mod12_tick", tick12, 1'b1);
        check("mod12_wrap", wrap12, 1'b1);
        check("mod24_wrap", wrap, 1'b0);
        i_run = 1'b0;
        @(posedge clk); #1;
        check("mod12_disp", d12, disp_exp(8'h00, 8'h00, 8'h00));
        check("mod24_disp", d24, disp_exp(8'h12, 8'h00, 8'h00));

        // Pause and resume keep the prescaler phase
        i_run = 1'b1;
        wait_tick(10, n);
        check("pause_tick0", n, 4);
        repeat (2) @(posedge clk);
        #1 i_run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (tick) cnt++;
        end
        check("pause_noticks", cnt, 0);
        i_run = 1'b1;
        wait_tick(10, n);
        check("resume_tick", n, 2);

        // Load on the cycle a tick is due: load wins, step discarded
        repeat (3) @(posedge clk);
        #1;
        set_hh = 8'h05; set_mm = 8'h06; set_ss = 8'h07; i_load = 1'b1;
        @(posedge clk); #1;
        i_load = 1'b0;
        check("coinc_notick", tick, 1'b0);
        check("coinc_noerr", load_err, 1'b0);
        @(posedge clk); #1;
        check("coinc_disp", d24, disp_exp(8'h05, 8'h06, 8'h07));
        wait_tick(10, n);
        check("coinc_next", n, 3);
        @(posedge clk); #1;
        check("coinc_disp2", d24, disp_exp(8'h05, 8'h06, 8'h08));

        // Asynchronous reset mid-count
        i_run = 1'b0;
        do_load(8'h00, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 8'h37, "arst_load");
        i_run = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_disp", d24, disp_exp(8'h00, 8'h00, 8'h00));
        check("arst_flags", {tick, wrap, expired, load_err}, 4'b0000);
        #3 rst_n = 1'b1;
        wait_tick(10, n);
        check("arst_first_tick", n, 4);
        @(posedge clk); #1;
        check("arst_after", d24, disp_exp(8'h00, 8'h00, 8'h01));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
